// File: rtl/dp_dtm_pkg.sv
// Shared types and constants for the JTAG debug transport module:
// TAP states, instruction codes, DMI op/status codes and DTMCS layout.
package dp_dtm_pkg;

    typedef enum logic [3:0] {
        TAP_TLR      = 4'h0,
        TAP_RTI      = 4'h1,
        TAP_SEL_DR   = 4'h2,
        TAP_CAP_DR   = 4'h3,
        TAP_SH_DR    = 4'h4,
        TAP_EX1_DR   = 4'h5,
        TAP_PAUSE_DR = 4'h6,
        TAP_EX2_DR   = 4'h7,
        TAP_UPD_DR   = 4'h8,
        TAP_SEL_IR   = 4'h9,
        TAP_CAP_IR   = 4'hA,
        TAP_SH_IR    = 4'hB,
        TAP_EX1_IR   = 4'hC,
        TAP_PAUSE_IR = 4'hD,
        TAP_EX2_IR   = 4'hE,
        TAP_UPD_IR   = 4'hF
    } tap_state_e;

    typedef enum logic [1:0] {
        DR_IDCODE = 2'd0,
        DR_DTMCS  = 2'd1,
        DR_DMI    = 2'd2,
        DR_BYPASS = 2'd3
    } dr_sel_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_DTMCS  = 5'h10;
    localparam logic [4:0] IR_DMI    = 5'h11;
    localparam logic [4:0] IR_BYPASS = 5'h1F;

    localparam logic [1:0] DMI_OP_READ   = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE  = 2'd2;
    localparam logic [1:0] DMI_ST_OK     = 2'd0;
    localparam logic [1:0] DMI_ST_FAILED = 2'd2;
    localparam logic [1:0] DMI_ST_BUSY   = 2'd3;

    localparam int DTMCS_VER_LSB   = 0;
    localparam int DTMCS_ABITS_LSB = 4;
    localparam int DTMCS_STAT_LSB  = 10;
    localparam int DTMCS_IDLE_LSB  = 12;
    localparam int DTMCS_DMIRESET  = 16;
    localparam int DTMCS_HARDRESET = 17;

    localparam logic [3:0] DTM_VERSION = 4'd1;

    // Any code with non-zero bits above bit 4 is unknown and selects BYPASS.
    function automatic dr_sel_e decode_ir(input logic [4:0] code, input logic upper_zero);
        dr_sel_e sel;
        sel = DR_BYPASS;
        if (upper_zero) begin
            case (code)
                IR_IDCODE: sel = DR_IDCODE;
                IR_DTMCS:  sel = DR_DTMCS;
                IR_DMI:    sel = DR_DMI;
                IR_BYPASS: sel = DR_BYPASS;
                default:   sel = DR_BYPASS;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/dp_dtm_tap.sv
// IEEE 1149.1 TAP controller: 16-state register advanced by tms, plus
// decoded capture/shift/update strobes for the current state.
module dp_tap_fsm
    import dp_dtm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic tms,
    output logic tlr,
    output logic capture_dr,
    output logic shift_dr,
    output logic update_dr,
    output logic capture_ir,
    output logic shift_ir,
    output logic update_ir
);

    tap_state_e state_q;
    tap_state_e state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TAP_TLR:      state_d = tms ? TAP_TLR    : TAP_RTI;
            TAP_RTI:      state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR:   state_d = tms ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR:   state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:    state_d = tms ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR:   state_d = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
            TAP_PAUSE_DR: state_d = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
            TAP_EX2_DR:   state_d = tms ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR:   state_d = tms ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR:   state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:    state_d = tms ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR:   state_d = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
            TAP_PAUSE_IR: state_d = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
            TAP_EX2_IR:   state_d = tms ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR:   state_d = tms ? TAP_SEL_DR : TAP_RTI;
            default:      state_d = TAP_TLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TAP_TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Actions take effect on the rising edge that leaves the named state.
    assign tlr        = (state_q == TAP_TLR);
    assign capture_dr = (state_q == TAP_CAP_DR);
    assign shift_dr   = (state_q == TAP_SH_DR);
    assign update_dr  = (state_q == TAP_UPD_DR);
    assign capture_ir = (state_q == TAP_CAP_IR);
    assign shift_ir   = (state_q == TAP_SH_IR);
    assign update_ir  = (state_q == TAP_UPD_IR);

endmodule

// File: rtl/dp_dtm.sv
// JTAG debug transport module: TAP, instruction register, IDCODE/DTMCS/DMI/
// BYPASS data registers and the DMI request/response handshake.
module dp_dtm
    import dp_dtm_pkg::*;
#(
    parameter int          ABITS       = 7,
    parameter int          IR_LEN      = 5,
    parameter logic [31:0] IDCODE_V    = 32'h1000_0001,
    parameter int          IDLE_CYCLES = 1
) (
    input  logic             iclk,
    input  logic             iresetn,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_rsp_valid,
    input  logic [31:0]      dmi_rsp_data,
    input  logic [1:0]       dmi_rsp_op
);

    localparam int DR_W = ABITS + 34;

    logic tlr;
    logic cap_dr;
    logic sh_dr;
    logic upd_dr;
    logic cap_ir;
    logic sh_ir;
    logic upd_ir;

    logic [IR_LEN-1:0] ir_sr_q;
    logic [IR_LEN-1:0] ir_sr_d;
    dr_sel_e           ir_sel_q;
    dr_sel_e           ir_sel_d;
    logic [DR_W-1:0]   dr_q;
    logic [DR_W-1:0]   dr_d;
    logic [1:0]        stat_q;
    logic [1:0]        stat_d;
    logic              busy_q;
    logic              busy_d;
    logic              req_valid_q;
    logic              req_valid_d;
    logic [ABITS-1:0]  last_addr_q;
    logic [ABITS-1:0]  last_addr_d;
    logic [31:0]       last_data_q;
    logic [31:0]       last_data_d;
    logic [1:0]        last_op_q;
    logic [1:0]        last_op_d;

    logic [31:0]       dtmcs_cap;
    logic              ir_upper_zero;
    logic              dmi_upd;
    logic              dtmcs_upd;
    logic              hard_reset;
    logic [ABITS-1:0]  upd_addr;
    logic [31:0]       upd_data;
    logic [1:0]        upd_op;

    dp_tap_fsm u_tap (
        .clk        (iclk),
        .rst_n      (iresetn),
        .tms        (tms),
        .tlr        (tlr),
        .capture_dr (cap_dr),
        .shift_dr   (sh_dr),
        .update_dr  (upd_dr),
        .capture_ir (cap_ir),
        .shift_ir   (sh_ir),
        .update_ir  (upd_ir)
    );

    always_comb begin
        dtmcs_cap = '0;
        dtmcs_cap[DTMCS_VER_LSB +: 4]   = DTM_VERSION;
        dtmcs_cap[DTMCS_ABITS_LSB +: 6] = 6'(ABITS);
        dtmcs_cap[DTMCS_STAT_LSB +: 2]  = stat_q;
        dtmcs_cap[DTMCS_IDLE_LSB +: 3]  = 3'(IDLE_CYCLES);
    end

    assign ir_upper_zero = ((ir_sr_q >> 5) == '0);
    assign dmi_upd       = upd_dr && (ir_sel_q == DR_DMI);
    assign dtmcs_upd     = upd_dr && (ir_sel_q == DR_DTMCS);
    assign hard_reset    = dtmcs_upd && dr_q[DTMCS_HARDRESET];
    assign upd_addr      = dr_q[DR_W-1 -: ABITS];
    assign upd_data      = dr_q[33:2];
    assign upd_op        = dr_q[1:0];

    // Instruction and data shift paths.
    always_comb begin
        ir_sr_d  = ir_sr_q;
        ir_sel_d = ir_sel_q;
        dr_d     = dr_q;

        if (cap_ir) begin
            ir_sr_d = IR_LEN'(2'b01);
        end else if (sh_ir) begin
            ir_sr_d = {tdi, ir_sr_q[IR_LEN-1:1]};
        end

        if (tlr) begin
            ir_sel_d = DR_IDCODE;
        end else if (upd_ir) begin
            ir_sel_d = decode_ir(ir_sr_q[4:0], ir_upper_zero);
        end

        if (cap_dr) begin
            case (ir_sel_q)
                DR_IDCODE: dr_d = {{(DR_W-32){1'b0}}, IDCODE_V};
                DR_DTMCS:  dr_d = {{(DR_W-32){1'b0}}, dtmcs_cap};
                DR_DMI:    dr_d = {last_addr_q, last_data_q, (busy_q ? DMI_ST_BUSY : stat_q)};
                default:   dr_d = '0;
            endcase
        end else if (sh_dr) begin
            case (ir_sel_q)
                DR_IDCODE,
                DR_DTMCS:  dr_d = {{(DR_W-32){1'b0}}, tdi, dr_q[31:1]};
                DR_DMI:    dr_d = {tdi, dr_q[DR_W-1:1]};
                default:   dr_d = {{(DR_W-1){1'b0}}, tdi};
            endcase
        end
    end

    // DMI transaction control; later assignments take priority.
    always_comb begin
        stat_d      = stat_q;
        busy_d      = busy_q;
        req_valid_d = req_valid_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        last_op_d   = last_op_q;

        if (req_valid_q && dmi_req_ready) begin
            req_valid_d = 1'b0;
        end

        if (cap_dr && (ir_sel_q == DR_DMI) && busy_q && (stat_q == DMI_ST_OK)) begin
            stat_d = DMI_ST_BUSY;
        end

        if (busy_q && dmi_rsp_valid && !hard_reset) begin
            busy_d      = 1'b0;
            last_data_d = dmi_rsp_data;
            if (dmi_rsp_op == DMI_ST_FAILED) begin
                stat_d = DMI_ST_FAILED;
            end else if (dmi_rsp_op == DMI_ST_BUSY) begin
                stat_d = DMI_ST_BUSY;
            end
        end

        if (dmi_upd && (stat_q == DMI_ST_OK)) begin
            if (busy_q) begin
                stat_d = DMI_ST_BUSY;
            end else if ((upd_op == DMI_OP_READ) || (upd_op == DMI_OP_WRITE)) begin
                last_addr_d = upd_addr;
                last_data_d = upd_data;
                last_op_d   = upd_op;
                busy_d      = 1'b1;
                req_valid_d = 1'b1;
            end
        end

        if (dtmcs_upd && dr_q[DTMCS_DMIRESET]) begin
            stat_d = DMI_ST_OK;
        end

        if (hard_reset) begin
            stat_d      = DMI_ST_OK;
            busy_d      = 1'b0;
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            ir_sel_q    <= DR_IDCODE;
            stat_q      <= DMI_ST_OK;
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
            last_op_q   <= '0;
        end else begin
            ir_sel_q    <= ir_sel_d;
            stat_q      <= stat_d;
            busy_q      <= busy_d;
            req_valid_q <= req_valid_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            last_op_q   <= last_op_d;
        end
    end

    // Shift registers are always captured before being shifted out.
    always_ff @(posedge iclk) begin
        ir_sr_q <= ir_sr_d;
        dr_q    <= dr_d;
    end

    always_comb begin
        tdo = 1'b0;
        if (sh_ir) begin
            tdo = ir_sr_q[0];
        end else if (sh_dr) begin
            tdo = dr_q[0];
        end
    end

    assign dmi_req_valid = req_valid_q;
    assign dmi_req_addr  = last_addr_q;
    assign dmi_req_data  = last_data_q;
    assign dmi_req_op    = last_op_q;

endmodule

// File: tb/tb_dp_dtm.sv
// Directed bench for dp_dtm: drives the TAP through IR/DR scans and plays
// the debug-module side of the DMI handshake.
module tb_dp_dtm;

    logic        iclk = 1'b0;
    logic        iresetn;
    logic        tms;
    logic        tdi;
    logic        tdo;
    logic        dmi_req_valid;
    logic        dmi_req_ready;
    logic [6:0]  dmi_req_addr;
    logic [31:0] dmi_req_data;
    logic [1:0]  dmi_req_op;
    logic        dmi_rsp_valid;
    logic [31:0] dmi_rsp_data;
    logic [1:0]  dmi_rsp_op;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 iclk = ~iclk;

    dp_dtm #(
        .ABITS       (7),
        .IR_LEN      (5),
        .IDCODE_V    (32'h1000_0001),
        .IDLE_CYCLES (1)
    ) dut (
        .iclk          (iclk),
        .iresetn       (iresetn),
        .tms           (tms),
        .tdi           (tdi),
        .tdo           (tdo),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req_addr  (dmi_req_addr),
        .dmi_req_data  (dmi_req_data),
        .dmi_req_op    (dmi_req_op),
        .dmi_rsp_valid (dmi_rsp_valid),
        .dmi_rsp_data  (dmi_rsp_data),
        .dmi_rsp_op    (dmi_rsp_op)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive tms/tdi in the low phase; tdo is read before the next rising edge.
    task automatic step(input logic t_ms, input logic t_di, output logic t_do);
        @(negedge iclk);
        tms = t_ms;
        tdi = t_di;
        #1 t_do = tdo;
    endtask

    task automatic idle();
        logic d;
        step(1'b0, 1'b0, d);
    endtask

    // From RUN_TEST_IDLE, scan the IR and return to RUN_TEST_IDLE.
    task automatic shift_ir(input logic [4:0] din, output logic [4:0] dout);
        logic d;
        dout = '0;
        step(1'b1, 1'b0, d);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        for (int i = 0; i < 5; i++) begin
            step(i == 4, din[i], d);
            dout[i] = d;
        end
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
    endtask

    // From RUN_TEST_IDLE, scan n DR bits; the update edge follows the return.
    task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
        logic d;
        dout = '0;
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
        step(1'b0, 1'b0, d);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], d);
            dout[i] = d;
        end
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, d);
    endtask

    task automatic pulse_rsp(input logic [1:0] op, input logic [31:0] data);
        dmi_rsp_valid = 1'b1;
        dmi_rsp_op    = op;
        dmi_rsp_data  = data;
        idle();
        dmi_rsp_valid = 1'b0;
        dmi_rsp_op    = 2'd0;
        dmi_rsp_data  = '0;
    endtask

    function automatic logic [63:0] dmi(input logic [6:0] a, input logic [31:0] dat, input logic [1:0] o);
        return {23'd0, a, dat, o};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  ir_out;
        logic [63:0] dr_out;

        iresetn       = 1'b0;
        tms           = 1'b1;
        tdi           = 1'b0;
        dmi_req_ready = 1'b0;
        dmi_rsp_valid = 1'b0;
        dmi_rsp_data  = '0;
        dmi_rsp_op    = 2'd0;
        #2;
        check("reset_tdo", 64'(tdo), 64'd0);
        check("reset_req_valid", 64'(dmi_req_valid), 64'd0);
        check("reset_req_addr", 64'(dmi_req_addr), 64'd0);
        check("reset_req_data", 64'(dmi_req_data), 64'd0);
        check("reset_req_op", 64'(dmi_req_op), 64'd0);
        @(negedge iclk);
        iresetn = 1'b1;
        idle();

        // Default IR after reset is IDCODE.
        shift_dr(64'd0, 32, dr_out);
        check("idcode_default", dr_out, 64'h1000_0001);

        shift_ir(5'h10, ir_out);
        check("ir_capture", 64'(ir_out), 64'h01);
        shift_dr(64'd0, 32, dr_out);
        check("dtmcs_reset", dr_out, 64'h0000_1071);

        // Write request held while ready is low, dropped after the handshake.
        shift_ir(5'h11, ir_out);
        shift_dr(dmi(7'h10, 32'hDEAD_BEEF, 2'd2), 41, dr_out);
        check("dmi_cap_idle", dr_out, dmi(7'h00, 32'h0, 2'd0));
        for (int i = 0; i < 3; i++) begin
            idle();
            check("wr_valid_held", 64'(dmi_req_valid), 64'd1);
            check("wr_payload", {23'd0, dmi_req_addr, dmi_req_data, dmi_req_op},
                  dmi(7'h10, 32'hDEAD_BEEF, 2'd2));
        end
        dmi_req_ready = 1'b1;
        idle();
        dmi_req_ready = 1'b0;
        check("wr_valid_drop", 64'(dmi_req_valid), 64'd0);
        pulse_rsp(2'd0, 32'h0);

        // Read with an ok response; data visible at the next DMI capture.
        shift_dr(dmi(7'h05, 32'h0, 2'd1), 41, dr_out);
        check("dmi_cap_after_wr", dr_out, dmi(7'h10, 32'h0, 2'd0));
        idle();
        check("rd_valid", 64'(dmi_req_valid), 64'd1);
        check("rd_op_addr", {55'd0, dmi_req_addr, dmi_req_op}, {55'd0, 7'h05, 2'd1});
        dmi_req_ready = 1'b1;
        idle();
        dmi_req_ready = 1'b0;
        check("rd_valid_drop", 64'(dmi_req_valid), 64'd0);
        pulse_rsp(2'd0, 32'h1234_5678);
        shift_dr(dmi(7'h00, 32'h0, 2'd0), 41, dr_out);
        check("rd_data", dr_out, dmi(7'h05, 32'h1234_5678, 2'd0));
        idle();
        check("nop_no_req", 64'(dmi_req_valid), 64'd0);

        // Update while busy is ignored and leaves a sticky busy status.
        shift_dr(dmi(7'h01, 32'hAAAA_5555, 2'd2), 41, dr_out);
        idle();
        dmi_req_ready = 1'b1;
        idle();
        dmi_req_ready = 1'b0;
        shift_dr(dmi(7'h02, 32'h1111_1111, 2'd2), 41, dr_out);
        check("busy_cap", dr_out, dmi(7'h01, 32'hAAAA_5555, 2'd3));
        idle();
        check("busy_upd_ignored_valid", 64'(dmi_req_valid), 64'd0);
        check("busy_upd_ignored_addr", 64'(dmi_req_addr), 64'h01);
        pulse_rsp(2'd0, 32'h0);
        shift_dr(dmi(7'h00, 32'h0, 2'd0), 41, dr_out);
        check("sticky_busy", dr_out, dmi(7'h01, 32'h0, 2'd3));
        shift_ir(5'h10, ir_out);
        shift_dr(64'h1_0000, 32, dr_out);
        check("dtmcs_stat3", dr_out, 64'h0000_1C71);
        shift_dr(64'd0, 32, dr_out);
        check("dtmcs_dmireset", dr_out, 64'h0000_1071);

        // Failed response sets status 2.
        shift_ir(5'h11, ir_out);
        shift_dr(dmi(7'h03, 32'h0, 2'd1), 41, dr_out);
        check("dmi_cap_cleared", dr_out, dmi(7'h01, 32'h0, 2'd0));
        idle();
        dmi_req_ready = 1'b1;
        idle();
        dmi_req_ready = 1'b0;
        pulse_rsp(2'd2, 32'hCAFE_F00D);
        shift_dr(dmi(7'h00, 32'h0, 2'd0), 41, dr_out);
        check("rsp_failed", dr_out, dmi(7'h03, 32'hCAFE_F00D, 2'd2));
        shift_ir(5'h10, ir_out);
        shift_dr(64'h1_0000, 32, dr_out);
        check("dtmcs_stat2", dr_out, 64'h0000_1871);

        // Hard reset while busy drops the request; a late response is discarded.
        shift_ir(5'h11, ir_out);
        shift_dr(dmi(7'h04, 32'h0000_0055, 2'd2), 41, dr_out);
        check("dmi_cap_pre_hr", dr_out, dmi(7'h03, 32'hCAFE_F00D, 2'd0));
        idle();
        check("hr_valid_before", 64'(dmi_req_valid), 64'd1);
        shift_ir(5'h10, ir_out);
        shift_dr(64'h2_0000, 32, dr_out);
        check("dtmcs_busy_stat", dr_out, 64'h0000_1071);
        idle();
        check("hr_valid_after", 64'(dmi_req_valid), 64'd0);
        pulse_rsp(2'd2, 32'hBADB_AD00);
        shift_ir(5'h11, ir_out);
        shift_dr(dmi(7'h00, 32'h0, 2'd0), 41, dr_out);
        check("late_rsp_ignored", dr_out, dmi(7'h04, 32'h0000_0055, 2'd0));

        // Five tms=1 reach TEST_LOGIC_RESET, which restores IDCODE.
        for (int i = 0; i < 5; i++) begin
            logic d;
            step(1'b1, 1'b0, d);
        end
        idle();
        shift_dr(64'd0, 32, dr_out);
        check("tlr_idcode", dr_out, 64'h1000_0001);

        // BYPASS explicit and via an unknown code.
        shift_ir(5'h1F, ir_out);
        shift_dr(64'b101, 3, dr_out);
        check("bypass", dr_out, 64'b010);
        shift_ir(5'h07, ir_out);
        shift_dr(64'b011, 3, dr_out);
        check("bypass_unknown", dr_out, 64'b110);

        // Asynchronous reset aborts a pending request immediately.
        shift_ir(5'h11, ir_out);
        shift_dr(dmi(7'h7F, 32'hFFFF_FFFF, 2'd2), 41, dr_out);
        idle();
        check("async_pre_valid", 64'(dmi_req_valid), 64'd1);
        #1 iresetn = 1'b0;
        #1;
        check("async_valid", 64'(dmi_req_valid), 64'd0);
        check("async_payload", {23'd0, dmi_req_addr, dmi_req_data, dmi_req_op}, 64'd0);
        @(negedge iclk);
        iresetn = 1'b1;
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dp_dtm.md
Name: dp_dtm

Overview:
Parametrised JTAG debug transport module, the next generation of the debug access port.
- Integrates the 16-state TAP controller, a configurable-length instruction register, and IDCODE, DTMCS, DMI and BYPASS data registers.
- Adds a DMI request/response handshake toward the debug module, with busy tracking and sticky error status.
- Sits between the JTAG pins and the debug module; all logic runs on the JTAG-derived internal clock.

Parameters:
ABITS, 7, DMI address width (minimum 1, maximum 32)
IR_LEN, 5, instruction register length (minimum 5)
IDCODE_V, 32'h1000_0001, IDCODE value; bit 0 must be 1
IDLE_CYCLES, 1, value reported in DTMCS.idle (0..7)

Ports:
iclk  in  1  internal clock (TCK domain); all flops on rising edge
iresetn  in  1  asynchronous active-low reset
tms  in  1  test mode select, sampled on iclk rise
tdi  in  1  test data in, sampled on iclk rise
tdo  out  1  test data out
dmi_req_valid  out  1  DMI request valid
dmi_req_ready  in  1  debug module accepts request
dmi_req_addr  out  ABITS  request address
dmi_req_data  out  32  request write data
dmi_req_op  out  2  1 = read, 2 = write
dmi_rsp_valid  in  1  response valid; always accepted, no ready
dmi_rsp_data  out... no: in  32  response read data
dmi_rsp_op  in  2  0 = ok, 2 = failed, 3 = busy

Behaviour:
Reset (iresetn=0):
- TAP state = TEST_LOGIC_RESET; IR = IDCODE.
- dmistat = 0, busy = 0.
- Last addr, data and op registers = 0.
- tdo = 0, dmi_req_valid = 0, dmi_req_addr/data/op = 0.

TAP controller:
- Standard IEEE 1149.1 16-state FSM, advanced by tms on each iclk rise.
- Five consecutive tms=1 reach TEST_LOGIC_RESET from any state.
- TEST_LOGIC_RESET loads IR = IDCODE only; DMI state is kept.

Instruction register:
- CAPTURE_IR loads {0..0, 2'b01}.
- SHIFT_IR shifts LSB first, tdi into the MSB.
- UPDATE_IR loads the decoded instruction.

Instruction decode:
- 0x01 IDCODE, 0x10 DTMCS, 0x11 DMI, 0x1F BYPASS.
- All other codes select BYPASS.

Data registers:
- Capture in CAPTURE_DR, shift LSB first in SHIFT_DR, act in UPDATE_DR.
- BYPASS: 1 bit, captures 0.

tdo:
- Combinational: LSB of the active shift register while in SHIFT_IR or SHIFT_DR; 0 otherwise.
- The host samples it at the next iclk rise.

DTMCS capture value:
- [31:18] = 0
- [17:16] = 0
- [14:12] = IDLE_CYCLES
- [11:10] = dmistat
- [9:4] = ABITS
- [3:0] = 1

DTMCS update:
- Bit 16 (dmireset) = 1 clears dmistat.
- Bit 17 (dmihardreset) = 1 clears dmistat and busy, and drops dmi_req_valid.
- An outstanding response arriving afterwards is discarded.
- All other bits are ignored.

DMI register (ABITS+34 bits, {addr, data[31:0], op[1:0]}):
- Capture when busy: op field = 3; sticky dmistat is set to 3 if currently 0.
- Capture when not busy: {last addr, last rsp data, dmistat}.

DMI update:
- Ignored if dmistat != 0.
- Ignored if busy; dmistat is set to 3.
- Otherwise op = 1 or 2 latches addr/data/op, sets busy, and asserts dmi_req_valid on the next cycle.
- op = 0 is a no-op; op = 3 is treated as no-op.

DMI request handshake:
- dmi_req_valid and its payload are held stable until dmi_req_ready=1.
- The request drops in the cycle after the handshake.
- busy stays 1 until dmi_rsp_valid.

DMI response (dmi_rsp_valid=1 while busy):
- Latch rsp data, clear busy.
- rsp_op = 2 sets dmistat = 2; rsp_op = 3 sets dmistat = 3.
- A response when not busy is ignored.

Priority and boundary cases:
- Same-cycle dmihardreset and rsp_valid: hardreset wins.
- Same-cycle rsp_valid and DMI capture: capture sees busy=1.
- Asynchronous reset mid-transaction aborts everything immediately.

Decomposition:
- Package dp_dtm_pkg: TAP state enum, instruction code constants, DMI op/status codes, DTMCS field positions, version constant.
- Sub-module dp_tap_fsm: TAP state register, next-state logic and decoded capture/shift/update strobes.

Test Plan:
- Reset, CAPTURE_DR/SHIFT_DR 32 bits with default IR -> tdo stream = 32'h1000_0001 LSB first.
- IR = 0x10, shift DTMCS -> 32'h0000_1071 (idle=1, abits=7, version=1).
- IR = 0x11, write {addr=7'h10, data=32'hDEAD_BEEF, op=2} -> req_valid held 3 cycles with ready=0; payload stable; drops after ready.
- Read op, respond rsp_op=0 with data 32'h1234_5678 -> next DMI capture shifts data 32'h1234_5678, op = 0.
- New DMI update before the response -> ignored; capture op=3; dmistat=3 sticky; DTMCS dmireset clears it to 0.
- rsp_op=2 -> dmistat=2; write with dmihardreset while busy -> busy=0, req_valid=0; late rsp_valid ignored; tms=1 ×5 -> IR = IDCODE.
